// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative RV32M multiply/divide; MULDIV_FASTPATH_EN enables 1-cycle div-by-zero/overflow results
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, step, mneg;
  logic [WIDTH-1:0] b_r, aa, ba, dval, res;
  logic [WIDTH:0] msum, drem, ddif;
  logic [2:0] op_r;
  logic neg, accept, asg, bsg, an, bn, nneg;
`ifdef MULDIV_FASTPATH_EN
  logic special;
  logic [WIDTH-1:0] fres;
`endif
  // operand conditioning: magnitudes and the sign to restore at the end
  always_comb begin
    accept = start && (state == IDLE || state == DONE);
    asg = Op == 3'b001 || Op == 3'b010 || (Op[2] && !Op[0]);
    bsg = Op == 3'b001 || (Op[2] && !Op[0]);
    an = asg && A[WIDTH-1];
    bn = bsg && B[WIDTH-1];
    aa = an ? -A : A;
    ba = bn ? -B : B;
    nneg = Op[2] ? (Op[1] ? an : (an ^ bn) & (|B)) : an ^ bn;
`ifdef MULDIV_FASTPATH_EN
    special = Op[2] && (B == '0 || (!Op[0] && A == {1'b1, {(WIDTH-1){1'b0}}} && B == '1));
    fres = B == '0 ? (Op[1] ? A : '1) : (Op[1] ? '0 : A);
`endif
  end
  // one iteration: shift-add multiply step or restoring divide step
  always_comb begin
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);
    drem = acc[2*WIDTH-1:WIDTH-1];
    ddif = drem - {1'b0, b_r};
    step = op_r[2] ? (ddif[WIDTH] ? {drem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {ddif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                   : {msum, acc[WIDTH-1:1]};
    mneg = neg ? -acc : acc;
    dval = op_r[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
    res = op_r[2] ? (neg ? -dval : dval) : (op_r[1:0] == 2'b00 ? mneg[WIDTH-1:0] : mneg[2*WIDTH-1:WIDTH]);
  end
  // control FSM with registered outputs
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      b_r <= '0;
      op_r <= '0;
      neg <= 1'b0;
      S <= '0;
      busy <= 1'b0;
    end else if (accept) begin
      op_r <= Op;
      neg <= nneg;
      acc <= {{WIDTH{1'b0}}, aa};
      b_r <= ba;
      cnt <= CW'(WIDTH - 1);
      state <= RUN;
      busy <= 1'b1;
`ifdef MULDIV_FASTPATH_EN
      if (special) begin
        state <= DONE;
        busy <= 1'b0;
        S <= fres;
        done <= 1'b1;
      end
`endif
    end else begin
      case (state)
        RUN: begin
          acc <= step;
          if (cnt == '0) state <= SIGN;
          else cnt <= cnt - 1'b1;
        end
        SIGN: begin
          S <= res;
          done <= 1'b1;
          busy <= 1'b0;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
